// File: rtl/pc_pkg.sv
// Shared types and constants for the PC / fetch-control stage.
package pc_pkg;

    typedef logic [31:0] pc_t;

    localparam pc_t RESET_VEC = 32'h8000_0000;
    localparam pc_t IRQ_VEC   = 32'h8000_0004;
    localparam pc_t EXC_VEC   = 32'h8000_0008;

    localparam logic [1:0] PCSRC_SEQ = 2'd0;
    localparam logic [1:0] PCSRC_BR  = 2'd1;
    localparam logic [1:0] PCSRC_J   = 2'd2;
    localparam logic [1:0] PCSRC_JR  = 2'd3;

endpackage

// File: rtl/pc_fetch_unit_if.sv
// Control/status bundle between the core (decoder, ALU, regfile) and the fetch unit.
interface pc_fetch_unit_if;
    import pc_pkg::*;

    logic [1:0]  pc_src;
    logic        branch_taken;
    logic [15:0] imm16;
    logic [25:0] jtarget;
    pc_t         jr_addr;
    logic        illop;
    logic        irq;

    pc_t         pc;
    pc_t         pc_plus4;
    logic        squash;
    logic        xp_we;
    pc_t         xp_data;
    logic        kernel;
    // Latched interrupt request; tied low when latching is compiled out.
    logic        irq_pending;

    modport master (
        output pc_src, branch_taken, imm16, jtarget, jr_addr, illop, irq,
        input  pc, pc_plus4, squash, xp_we, xp_data, kernel, irq_pending
    );

    modport slave (
        input  pc_src, branch_taken, imm16, jtarget, jr_addr, illop, irq,
        output pc, pc_plus4, squash, xp_we, xp_data, kernel, irq_pending
    );

endinterface

// File: rtl/pc_next_mux.sv
// Combinational next-PC target computation and priority select
// (exception > interrupt > pc_src). Reset is applied at the PC register.
module pc_next_mux
    import pc_pkg::*;
#(
    parameter pc_t IRQ_VEC_P = pc_pkg::IRQ_VEC,
    parameter pc_t EXC_VEC_P = pc_pkg::EXC_VEC
) (
    input  pc_t         pc,
    input  logic [1:0]  pc_src,
    input  logic        branch_taken,
    input  logic [15:0] imm16,
    input  logic [25:0] jtarget,
    input  pc_t         jr_addr,
    input  logic        exc,
    input  logic        irq_take,
    output pc_t         pc_plus4,
    output pc_t         next_pc
);

    logic [30:0] low_plus4;
    pc_t         br_sum;
    pc_t         br_target;
    pc_t         j_target;

    // Only the low 31 bits increment; the kernel bit never carries.
    assign low_plus4 = pc[30:0] + 31'd4;
    assign pc_plus4  = {pc[31], low_plus4};

    assign br_sum    = pc_plus4 + {{14{imm16[15]}}, imm16, 2'b00};
    assign br_target = {pc[31], br_sum[30:0]};
    assign j_target  = {pc[31:28], jtarget, 2'b00};

    always_comb begin
        next_pc = pc_plus4;
        if (exc) begin
            next_pc = EXC_VEC_P;
        end else if (irq_take) begin
            next_pc = IRQ_VEC_P;
        end else begin
            case (pc_src)
                PCSRC_SEQ: next_pc = pc_plus4;
                PCSRC_BR:  next_pc = branch_taken ? br_target : pc_plus4;
                PCSRC_J:   next_pc = j_target;
                PCSRC_JR:  next_pc = jr_addr;
                default:   next_pc = pc_plus4;
            endcase
        end
    end

endmodule

// File: rtl/pc_fetch_unit.sv
// PC register, kernel bit, interrupt/exception entry and $26 writeback.
// Optional build macro IRQ_LATCH_EN: edge-latched interrupt requests.
module pc_fetch_unit #(
    parameter pc_pkg::pc_t RESET_VEC = pc_pkg::RESET_VEC,
    parameter pc_pkg::pc_t IRQ_VEC   = pc_pkg::IRQ_VEC,
    parameter pc_pkg::pc_t EXC_VEC   = pc_pkg::EXC_VEC
) (
    input  logic             clk,
    input  logic             reset,
    pc_fetch_unit_if.slave   bus
);
    import pc_pkg::*;

    pc_t  pc_q;
    pc_t  next_pc;
    pc_t  pc_plus4;
    logic kernel;
    logic irq_active;
    logic exc;
    logic irq_take;
    logic event_taken;

    assign kernel = pc_q[31];

    // Reset masks both entry events so squash/xp_we stay low while it is high.
    assign exc         = bus.illop & ~reset;
    assign irq_take    = irq_active & ~kernel & ~bus.illop & ~reset;
    assign event_taken = exc | irq_take;

`ifdef IRQ_LATCH_EN
    logic pending_q;
    logic irq_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            pending_q <= 1'b0;
            irq_q     <= 1'b0;
        end else begin
            irq_q <= bus.irq;
            if (irq_take) begin
                pending_q <= 1'b0;
            end else if (bus.irq && !irq_q) begin
                pending_q <= 1'b1;
            end
        end
    end

    assign irq_active      = pending_q;
    assign bus.irq_pending = pending_q;
`else
    assign irq_active      = bus.irq;
    assign bus.irq_pending = 1'b0;
`endif

    pc_next_mux #(
        .IRQ_VEC_P (IRQ_VEC),
        .EXC_VEC_P (EXC_VEC)
    ) u_next_mux (
        .pc           (pc_q),
        .pc_src       (bus.pc_src),
        .branch_taken (bus.branch_taken),
        .imm16        (bus.imm16),
        .jtarget      (bus.jtarget),
        .jr_addr      (bus.jr_addr),
        .exc          (exc),
        .irq_take     (irq_take),
        .pc_plus4     (pc_plus4),
        .next_pc      (next_pc)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q <= RESET_VEC;
        end else begin
            pc_q <= next_pc;
        end
    end

    assign bus.pc       = pc_q;
    assign bus.pc_plus4 = pc_plus4;
    assign bus.kernel   = kernel;
    assign bus.squash   = event_taken;
    assign bus.xp_we    = event_taken;
    // On entry $26 gets the squashed instruction's PC so jr $26 re-executes it.
    assign bus.xp_data  = event_taken ? pc_q : pc_plus4;

endmodule
